mm_mac_accum: RTL

MM_MAC_ACCUM -- requirements
Module: mm_mac_accum

---
 rtl/mm_mac_accum.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mm_mac_accum.sv
// Pipelined multiply-accumulate for a matrix-vector product: capture, multiply, accumulate,
// then write the row sum into a small result memory P with a read port.
module mm_mac_accum #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned ACCW   = 20,
  parameter int unsigned N_ROWS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mac_en,
  input  logic            control,
  input  logic            result_en,
  input  logic [AW-1:0]   addr_P,
  input  logic [DW-1:0]   data_A,
  input  logic [DW-1:0]   data_x,
  input  logic            clr_ovf,
  input  logic [AW-1:0]   rd_addr,
  output logic [ACCW-1:0] rd_data,
  output logic            p_valid,
  output logic [AW-1:0]   p_addr,
  output logic [ACCW-1:0] p_data,
  output logic            done,
  output logic            ovf
);

  localparam int Depth = 2 ** AW;
  localparam int unsigned CW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  // Stage 0: input capture
  logic [DW-1:0]   a_q, x_q;
  logic            ctl0_q, res0_q, v0_q;
  logic [AW-1:0]   addr0_q;
  // Stage 1: product
  logic [ACCW-1:0] prod_q;
  logic            ctl1_q, res1_q, v1_q;
  logic [AW-1:0]   addr1_q;
  // Stage 2: accumulator
  logic [ACCW-1:0] acc_q, acc_d;
  logic            res2_q, v2_q, ovf_q, ovf_d, sat;
  logic [AW-1:0]   addr2_q;
  // Stage 3: result memory and write report
  logic [ACCW-1:0] p_mem [Depth];
  logic            p_valid_q, done_q;
  logic [AW-1:0]   p_addr_q;
  logic [ACCW-1:0] p_data_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr, cnt_wrap;

  logic [2*DW-1:0] mult;
  logic [ACCW:0]   sum;

  assign mult = a_q * x_q;
  // One extra bit catches a carry out of the accumulator for saturation.
  assign sum  = {1'b0, acc_q} + {1'b0, prod_q};

  always_comb begin
    acc_d = acc_q;
    sat   = 1'b0;
    if (v1_q) begin
      if (ctl1_q) begin
        acc_d = prod_q;
      end else if (sum[ACCW]) begin
        acc_d = '1;
        sat   = 1'b1;
      end else begin
        acc_d = sum[ACCW-1:0];
      end
    end
  end

  // A saturation at the same edge as clr_ovf keeps the flag set.
  assign ovf_d = sat | (ovf_q & ~clr_ovf);

  assign wr       = v2_q & res2_q;
  assign cnt_wrap = (cnt_q == CW'(N_ROWS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (wr) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      x_q     <= '0;
      ctl0_q  <= 1'b0;
      res0_q  <= 1'b0;
      v0_q    <= 1'b0;
      addr0_q <= '0;
      prod_q  <= '0;
      ctl1_q  <= 1'b0;
      res1_q  <= 1'b0;
      v1_q    <= 1'b0;
      addr1_q <= '0;
      acc_q   <= '0;
      res2_q  <= 1'b0;
      v2_q    <= 1'b0;
      addr2_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= data_A;
      x_q     <= data_x;
      ctl0_q  <= control;
      res0_q  <= result_en;
      v0_q    <= mac_en;
      addr0_q <= addr_P;
      prod_q  <= ACCW'(mult);
      ctl1_q  <= ctl0_q;
      res1_q  <= res0_q;
      v1_q    <= v0_q;
      addr1_q <= addr0_q;
      acc_q   <= acc_d;
      res2_q  <= res1_q;
      v2_q    <= v1_q;
      addr2_q <= addr1_q;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        p_mem[i] <= '0;
      end
      p_valid_q <= 1'b0;
      p_addr_q  <= '0;
      p_data_q  <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (wr) begin
        p_mem[addr2_q] <= acc_q;
        p_addr_q       <= addr2_q;
        p_data_q       <= acc_q;
      end
      p_valid_q <= wr;
      done_q    <= wr & cnt_wrap;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_data = p_mem[rd_addr];
  assign p_valid = p_valid_q;
  assign p_addr  = p_addr_q;
  assign p_data  = p_data_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule
